// File: rtl/aes128_inv_cipher_core.sv
// Iterative AES-128 decryption: key expansion (10 clk), initial AddRoundKey, 9 inverse rounds, final round.
// done_o rises 21 clocks after an accepted start; start_i is dropped (not queued) while busy_o is high.
package aes128_inv_cipher_pkg;
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction
endpackage

module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   import aes128_inv_cipher_pkg::*;
   logic [7:0] inv;
   assign inv   = gf_inv(in_i);
   assign out_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   import aes128_inv_cipher_pkg::*;
   logic [7:0] pre;
   assign pre   = rotl8(in_i, 1) ^ rotl8(in_i, 3) ^ rotl8(in_i, 6) ^ 8'h05;
   assign out_o = gf_inv(pre);
endmodule

module aes128_inv_cipher_core (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [127:0] ciphertext_i,
   input  logic [127:0] key_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [127:0] plaintext_o
);
   import aes128_inv_cipher_pkg::*;

   typedef enum logic [2:0] {S_IDLE, S_KEXP, S_FIRST, S_ROUND, S_FINAL} state_e;

   state_e       fsm_q, fsm_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] st_q, st_d, pt_q, pt_d;
   logic         busy_q, busy_d, done_q, done_d;
   logic [127:0] rk_q [0:10];

   logic [127:0] rk_prev, rk_cur, rk_next;
   logic [31:0]  rot_w, sub_w, w0, w1, w2, w3;
   logic [7:0]   rcon;
   logic [127:0] isr, isb, ark, imc, ptf;

   assign rk_prev = (cnt_q == 4'd0) ? rk_q[0] : rk_q[cnt_q - 4'd1];
   assign rk_cur  = rk_q[cnt_q];
   assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};

   always_comb begin
      rcon = 8'h00;
      case (cnt_q)
         4'd1:  rcon = 8'h01;
         4'd2:  rcon = 8'h02;
         4'd3:  rcon = 8'h04;
         4'd4:  rcon = 8'h08;
         4'd5:  rcon = 8'h10;
         4'd6:  rcon = 8'h20;
         4'd7:  rcon = 8'h40;
         4'd8:  rcon = 8'h80;
         4'd9:  rcon = 8'h1b;
         4'd10: rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign w0      = rk_prev[127:96] ^ sub_w ^ {rcon, 24'h000000};
   assign w1      = rk_prev[95:64] ^ w0;
   assign w2      = rk_prev[63:32] ^ w1;
   assign w3      = rk_prev[31:0] ^ w2;
   assign rk_next = {w0, w1, w2, w3};

   // state byte (row r, column c) lives at bits [127-8*(r+4c) -: 8]
   always_comb begin
      isr = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            isr[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c+4-r)%4)) -: 8];
         end
      end
   end

   for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
      aes_inv_sbox u_isb (.in_i(isr[8*g +: 8]), .out_o(isb[8*g +: 8]));
   end

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sb (.in_i(rot_w[8*g +: 8]), .out_o(sub_w[8*g +: 8]));
   end

   assign ark = isb ^ rk_cur;
   assign ptf = isb ^ rk_q[0];

   always_comb begin
      logic [7:0] a [0:3];
      logic [7:0] x2, x4, x8;
      logic [7:0] m9 [0:3];
      logic [7:0] mb [0:3];
      logic [7:0] md [0:3];
      logic [7:0] me [0:3];
      imc = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r]  = ark[127-8*(r+4*c) -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
         end
         imc[127-8*(0+4*c) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         imc[127-8*(1+4*c) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         imc[127-8*(2+4*c) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         imc[127-8*(3+4*c) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
   end

   always_comb begin
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      st_d   = st_q;
      pt_d   = pt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            if (start_i) begin
               st_d   = ciphertext_i;
               cnt_d  = 4'd1;
               busy_d = 1'b1;
               fsm_d  = S_KEXP;
            end
         end
         S_KEXP: begin
            if (cnt_q == 4'd10) fsm_d = S_FIRST;
            else                cnt_d = cnt_q + 4'd1;
         end
         S_FIRST: begin
            st_d  = st_q ^ rk_q[10];
            cnt_d = 4'd9;
            fsm_d = S_ROUND;
         end
         S_ROUND: begin
            st_d = imc;
            if (cnt_q == 4'd1) fsm_d = S_FINAL;
            else               cnt_d = cnt_q - 4'd1;
         end
         S_FINAL: begin
            pt_d   = ptf;
            done_d = 1'b1;
            busy_d = 1'b0;
            cnt_d  = 4'd0;
            fsm_d  = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q  <= S_IDLE;
         cnt_q  <= 4'd0;
         st_q   <= '0;
         pt_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         st_q   <= st_d;
         pt_q   <= pt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && fsm_q == S_IDLE && start_i) rk_q[0] <= key_i;
      else if (fsm_q == S_KEXP)                 rk_q[cnt_q] <= rk_next;
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign plaintext_o = pt_q;
endmodule
